// File: rtl/line_fetcher_if.sv
// rtl/line_fetcher_if.sv - memory-bus read request/response bundle for line_fetcher
interface line_fetcher_if #(
  parameter int ADDR_WIDTH = 30
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_read_req;
  logic                  bus_ready;
  logic [31:0]           bus_read_data;
  logic                  bus_read_data_valid;

  modport master (
    output bus_addr, bus_read_req,
    input  bus_ready, bus_read_data, bus_read_data_valid
  );

  modport slave (
    input  bus_addr, bus_read_req,
    output bus_ready, bus_read_data, bus_read_data_valid
  );
endinterface

// File: rtl/line_fetcher.sv
// rtl/line_fetcher.sv - issues WORDS single-word reads for one aligned line and forwards
// in-order responses to the word-collecting buffer, with abort/drain handling.
module line_fetcher #(
  parameter int WORDS      = 4,
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  line_fetcher_if.master        bus,
  output logic                  buf_clear,
  output logic [31:0]           buf_read_data,
  output logic                  buf_read_data_valid
);
  localparam int IW = $clog2(WORDS);
  localparam int CW = IW + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         received_q, received_d;
  logic                  clear_q, clear_d;
  logic                  req, fwd, done_c, rsp;

  assign rsp = bus.bus_read_data_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      received_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      clear_q    <= clear_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    received_d = received_q;
    clear_d    = 1'b0;
    req        = 1'b0;
    fwd        = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = line_addr & LINE_MASK;
          addr_d     = line_addr & LINE_MASK;
          issued_d   = '0;
          received_d = '0;
          clear_d    = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        received_d = received_q + CW'(rsp);
        // Abort wins over a same-cycle response: it is counted, never forwarded.
        if (abort) begin
          state_d = (received_d == issued_q) ? S_IDLE : S_DRAIN;
        end else begin
          fwd = rsp;
          if (state_q == S_ISSUE) begin
            req = 1'b1;
            if (bus.bus_ready) begin
              issued_d = issued_q + CW'(1);
              addr_d   = base_q + ADDR_WIDTH'(issued_d);
              if (issued_d == CW'(WORDS)) state_d = S_WAIT;
            end
          end else if (received_d == CW'(WORDS)) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        received_d = received_q + CW'(rsp);
        if (received_d == issued_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy                = (state_q != S_IDLE);
  assign done                = done_c;
  assign buf_clear           = clear_q;
  assign buf_read_data_valid = fwd;
  assign buf_read_data       = fwd ? bus.bus_read_data : 32'h0;
  assign bus.bus_read_req    = req;
  assign bus.bus_addr        = addr_q;
endmodule

// File: tb/tb_line_fetcher.sv
// tb/tb_line_fetcher.sv - randomized and directed bench for line_fetcher against a
// line-level reference model and an in-order memory responder.
module tb_line_fetcher;
  localparam int W  = 4;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] line_addr = '0;
  logic          busy, done, buf_clear, buf_valid;
  logic [31:0]   buf_data;

  line_fetcher_if #(.ADDR_WIDTH(AW)) bus_if ();

  line_fetcher #(.WORDS(W), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .line_addr           (line_addr),
    .abort               (abort),
    .busy                (busy),
    .done                (done),
    .bus                 (bus_if),
    .buf_clear           (buf_clear),
    .buf_read_data       (buf_data),
    .buf_read_data_valid (buf_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Line-level model: mode 0 idle, 1 fetching, 2 draining.
  int            m_mode = 0;
  int            m_issued = 0;
  int            m_received = 0;
  logic [AW-1:0] m_base = '0;
  bit            m_clear = 1'b0;

  // Bus responder: accepted addresses answered in order after dmin..dmax edges.
  logic [AW-1:0] rq_addr[$];
  int            rq_due[$];
  int            edges = 0;
  int            last_due = 0;
  bit            presenting = 1'b0;
  int            dmin = 1;
  int            dmax = 1;
  bit            spur_en = 1'b0;

  int            n_done, n_strobes, n_clear, n_accept;
  logic [AW-1:0] first_addr;
  bit            first_seen;

  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_A5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_stats();
    n_done = 0; n_strobes = 0; n_clear = 0; n_accept = 0; first_seen = 1'b0; first_addr = '0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_issued = 0; m_received = 0; m_base = '0; m_clear = 1'b0;
  endtask

  function automatic bit exp_req();
    return (m_mode == 1) && (m_issued < W) && !abort;
  endfunction

  task automatic compare();
    bit er, ef;
    er = exp_req();
    ef = (m_mode == 1) && !abort && bus_if.bus_read_data_valid;
    check("busy", busy, m_mode != 0);
    check("bus_read_req", bus_if.bus_read_req, er);
    if (er) check("bus_addr", bus_if.bus_addr, m_base + AW'(m_issued));
    check("buf_valid", buf_valid, ef);
    if (ef) check("buf_data", buf_data, mem(m_base + AW'(m_received)));
    check("done", done, ef && (m_received + 1 == W));
    check("buf_clear", buf_clear, m_clear);
    if (buf_valid) n_strobes++;
    if (done) n_done++;
    if (buf_clear) n_clear++;
  endtask

  task automatic update();
    bit acc, rsp, new_clear;
    int due;
    acc = exp_req() && bus_if.bus_ready;
    rsp = bus_if.bus_read_data_valid;
    edges++;
    if (presenting) begin
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end
    presenting = 1'b0;
    if (bus_if.bus_read_req && bus_if.bus_ready) begin
      n_accept++;
      if (!first_seen) begin first_addr = bus_if.bus_addr; first_seen = 1'b1; end
      due = edges + $urandom_range(dmin, dmax);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq_addr.push_back(bus_if.bus_addr);
      rq_due.push_back(due);
    end
    new_clear = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      case (m_mode)
        0: if (start) begin
          m_base = line_addr & ~AW'(W - 1);
          m_issued = 0; m_received = 0; m_mode = 1; new_clear = 1'b1;
        end
        1: begin
          m_received += int'(rsp);
          if (abort) m_mode = (m_issued == m_received) ? 0 : 2;
          else begin
            if (acc) m_issued++;
            if (m_received == W) m_mode = 0;
          end
        end
        default: begin
          m_received += int'(rsp);
          if (m_received == m_issued) m_mode = 0;
        end
      endcase
      m_clear = new_clear;
    end
  endtask

  task automatic present();
    if (rq_addr.size() > 0 && rq_due[0] <= edges + 1) begin
      bus_if.bus_read_data_valid = 1'b1;
      bus_if.bus_read_data = mem(rq_addr[0]);
      presenting = 1'b1;
    end else if (spur_en && m_mode == 0 && $urandom_range(0, 3) == 0) begin
      bus_if.bus_read_data_valid = 1'b1;
      bus_if.bus_read_data = $urandom;
    end else begin
      bus_if.bus_read_data_valid = 1'b0;
      bus_if.bus_read_data = $urandom;
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rdy);
    start = st; abort = ab; bus_if.bus_ready = rdy;
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
    present();
  endtask

  task automatic wait_idle(input int budget, input int rdy_mode, input string name);
    int k;
    k = 0;
    while (m_mode != 0 && k < budget) begin
      case (rdy_mode)
        0: step(1'b0, 1'b0, 1'b1);
        1: step(1'b0, 1'b0, (k % 3) == 0);
        default: step(1'b0, 1'b0, $urandom_range(0, 3) != 0);
      endcase
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_read_data_valid = 1'b0;
    bus_if.bus_read_data = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_req", bus_if.bus_read_req, 1'b0);
    check("reset_addr", bus_if.bus_addr, '0);
    check("reset_clear", buf_clear, 1'b0);
    check("reset_valid", buf_valid, 1'b0);
    check("reset_done", done, 1'b0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);

    // 1: basic line at 0x105, responses 2 edges after accept
    dmin = 2; dmax = 2; clear_stats();
    line_addr = 30'h105;
    step(1'b1, 1'b0, 1'b1);
    check("t1_model_base", m_base, 30'h104);
    wait_idle(40, 0, "t1_idle");
    check("t1_first_addr", first_addr, 30'h104);
    check("t1_accepts", n_accept, 4);
    check("t1_strobes", n_strobes, 4);
    check("t1_done", n_done, 1);
    check("t1_clear", n_clear, 1);

    // 2: ready stalls 1,0,0,...
    dmin = 1; dmax = 3; clear_stats();
    line_addr = 30'h2_0003;
    step(1'b1, 1'b0, 1'b1);
    wait_idle(80, 1, "t2_idle");
    check("t2_accepts", n_accept, 4);
    check("t2_strobes", n_strobes, 4);
    check("t2_done", n_done, 1);

    // 3: abort after 2 accepts with no responses yet
    dmin = 8; dmax = 8; clear_stats();
    line_addr = 30'h3F0;
    step(1'b1, 1'b0, 1'b1);
    k = 0;
    while (n_accept < 2 && k < 20) begin step(1'b0, 1'b0, 1'b1); k++; end
    check("t3_accepts", n_accept, 2);
    step(1'b0, 1'b1, 1'b1);
    check("t3_model_drain", m_mode, 2);
    check("t3_busy_drain", busy, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    wait_idle(40, 0, "t3_idle");
    check("t3_strobes", n_strobes, 0);
    check("t3_done", n_done, 0);
    check("t3_accepts_after", n_accept, 2);

    // 4: abort coincident with the 4th response
    dmin = 2; dmax = 2; clear_stats();
    line_addr = 30'h77;
    step(1'b1, 1'b0, 1'b1);
    k = 0;
    while (!(bus_if.bus_read_data_valid && m_received == 3) && k < 40) begin
      step(1'b0, 1'b0, 1'b1); k++;
    end
    check("t4_reached", m_received, 3);
    step(1'b0, 1'b1, 1'b1);
    check("t4_idle_next", busy, 1'b0);
    check("t4_strobes", n_strobes, 3);
    check("t4_done", n_done, 0);

    // 5: start held through the fetch, spurious strobes in IDLE
    dmin = 1; dmax = 2; spur_en = 1'b1; clear_stats();
    line_addr = 30'h1234;
    k = 0;
    while (n_done == 0 && k < 40) begin step(1'b1, 1'b0, 1'b1); k++; end
    repeat (10) step(1'b0, 1'b0, 1'b1);
    check("t5_clear", n_clear, 1);
    check("t5_strobes", n_strobes, 4);
    check("t5_done", n_done, 1);
    spur_en = 1'b0;

    // 6: reset mid-WAIT, then a clean fetch
    dmin = 6; dmax = 6; clear_stats();
    line_addr = 30'h5551;
    step(1'b1, 1'b0, 1'b1);
    k = 0;
    while (!(m_mode == 1 && m_issued == W) && k < 20) begin step(1'b0, 1'b0, 1'b1); k++; end
    check("t6_in_wait", m_issued, W);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_req", bus_if.bus_read_req, 1'b0);
    check("t6_rst_addr", bus_if.bus_addr, '0);
    check("t6_rst_valid", buf_valid, 1'b0);
    check("t6_rst_data", buf_data, '0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_clear", buf_clear, 1'b0);
    k = 0;
    while (rq_addr.size() > 0 && k < 30) begin step(1'b0, 1'b0, 1'b1); k++; end
    reset_n = 1'b1;
    dmin = 1; dmax = 3; clear_stats();
    line_addr = 30'h0ABC;
    step(1'b1, 1'b0, 1'b1);
    wait_idle(60, 2, "t6_idle");
    check("t6_strobes", n_strobes, 4);
    check("t6_done", n_done, 1);

    // Random traffic
    spur_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin dmin = 1; dmax = $urandom_range(1, 5); end
      line_addr = AW'($urandom);
      step($urandom_range(0, 2) == 0,
           (m_mode != 0) && ($urandom_range(0, 29) == 0),
           $urandom_range(0, 3) != 0);
    end
    wait_idle(100, 2, "rand_idle");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
